vc_mc_queue: RTL and testbench

- Multi-channel queue: p_num_chans independent FIFO channels share one 1r1w storage array, statically partitioned into p_num_msgs slots per channel.
- One enqueue port and one dequeue port, each steered by a channel index.
- Successor to the single-channel val/rdy queue. Adds per-channel occupancy, per-channel flush, and strict isolation: one channel's state never affects another channel's rdy/val.
- Used between per-domain producers and consumers that share a physical buffer.

---
 rtl/vc_queue_pkg.sv | 14 +
 rtl/vc_mc_queue_chan_ctrl.sv | 95 +++++++++
 rtl/vc_mc_queue.sv | 112 +++++++++++
 tb/tb_vc_mc_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vc_queue_pkg.sv
// Shared queue-mode constants and the pointer-wrap helper used by the
// single- and multi-channel val/rdy queues.
package vc_queue_pkg;

    localparam int VC_QUEUE_NORMAL = 0;
    localparam int VC_QUEUE_PIPE   = 1;
    localparam int VC_QUEUE_BYPASS = 2;

    // Pointers wrap at an arbitrary depth, not just powers of two.
    function automatic int ptr_inc(input int ptr, input int num_msgs);
        return (ptr >= num_msgs - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/vc_mc_queue_chan_ctrl.sv
// One channel's pointers, full bit and free count.
// With VC_MC_QUEUE_HWM_EN defined, also tracks a high-water-mark occupancy.
module vc_mc_queue_chan_ctrl
    import vc_queue_pkg::*;
#(
    parameter  int p_num_msgs   = 4,
    localparam int c_addr_nbits = $clog2(p_num_msgs),
    localparam int c_cnt_nbits  = c_addr_nbits + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    do_enq,
    input  logic                    do_deq,
    input  logic                    do_bypass,
    input  logic                    flush,
    output logic [c_addr_nbits-1:0] enq_ptr,
    output logic [c_addr_nbits-1:0] deq_ptr,
    output logic                    full,
    output logic                    empty,
`ifdef VC_MC_QUEUE_HWM_EN
    output logic [c_cnt_nbits-1:0]  hwm,
`endif
    output logic [c_cnt_nbits-1:0]  num_free
);

    logic [c_addr_nbits-1:0] r_enq_ptr, r_deq_ptr, w_enq_ptr_next, w_deq_ptr_next;
    logic [c_addr_nbits-1:0] w_enq_ptr_inc, w_deq_ptr_inc;
    logic                    r_full, w_full_next, w_enq, w_deq;

    function automatic logic [c_cnt_nbits-1:0] occupancy(
        input logic [c_addr_nbits-1:0] ep,
        input logic [c_addr_nbits-1:0] dp,
        input logic                    f
    );
        int diff;
        diff = int'(ep) - int'(dp);
        if (diff < 0) diff = diff + p_num_msgs;
        return f ? c_cnt_nbits'(p_num_msgs) : c_cnt_nbits'(diff);
    endfunction

    assign w_enq_ptr_inc = c_addr_nbits'(ptr_inc(int'(r_enq_ptr), p_num_msgs));
    assign w_deq_ptr_inc = c_addr_nbits'(ptr_inc(int'(r_deq_ptr), p_num_msgs));
    // A bypass transfer never touches storage, so it moves no pointer.
    assign w_enq = do_enq && !do_bypass;
    assign w_deq = do_deq && !do_bypass;

    always_comb begin
        w_enq_ptr_next = r_enq_ptr;
        w_deq_ptr_next = r_deq_ptr;
        w_full_next    = r_full;
        if (flush) begin
            w_enq_ptr_next = '0;
            w_deq_ptr_next = '0;
            w_full_next    = 1'b0;
        end else begin
            if (w_enq) w_enq_ptr_next = w_enq_ptr_inc;
            if (w_deq) w_deq_ptr_next = w_deq_ptr_inc;
            if (w_enq && !w_deq && (w_enq_ptr_inc == r_deq_ptr))
                w_full_next = 1'b1;
            else if (w_deq && !w_enq)
                w_full_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enq_ptr <= '0;
            r_deq_ptr <= '0;
            r_full    <= 1'b0;
        end else begin
            r_enq_ptr <= w_enq_ptr_next;
            r_deq_ptr <= w_deq_ptr_next;
            r_full    <= w_full_next;
        end
    end

    assign enq_ptr  = r_enq_ptr;
    assign deq_ptr  = r_deq_ptr;
    assign full     = r_full;
    assign empty    = !r_full && (r_enq_ptr == r_deq_ptr);
    assign num_free = c_cnt_nbits'(p_num_msgs) - occupancy(r_enq_ptr, r_deq_ptr, r_full);

`ifdef VC_MC_QUEUE_HWM_EN
    logic [c_cnt_nbits-1:0] r_hwm, w_occ_next;
    assign w_occ_next = occupancy(w_enq_ptr_next, w_deq_ptr_next, w_full_next);

    always_ff @(posedge clk) begin
        if (reset)                   r_hwm <= '0;
        else if (w_occ_next > r_hwm) r_hwm <= w_occ_next;
    end

    assign hwm = r_hwm;
`endif

endmodule

// File: rtl/vc_mc_queue.sv
// Multi-channel val/rdy queue: p_num_chans FIFOs statically partitioned in one 1r1w array.
// Define VC_MC_QUEUE_HWM_EN to add the per-channel high-water-mark output hwm.
module vc_mc_queue
    import vc_queue_pkg::*;
#(
    parameter  int p_type       = VC_QUEUE_NORMAL,
    parameter  int p_msg_nbits  = 32,
    parameter  int p_num_msgs   = 4,
    parameter  int p_num_chans  = 2,
    localparam int c_addr_nbits = $clog2(p_num_msgs),
    localparam int c_chan_nbits = $clog2(p_num_chans)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    enq_val,
    output logic                                    enq_rdy,
    input  logic [c_chan_nbits-1:0]                 enq_chan,
    input  logic [p_msg_nbits-1:0]                  enq_msg,
    output logic                                    deq_val,
    input  logic                                    deq_rdy,
    input  logic [c_chan_nbits-1:0]                 deq_chan,
    output logic [p_msg_nbits-1:0]                  deq_msg,
    input  logic                                    flush,
    input  logic [c_chan_nbits-1:0]                 flush_chan,
`ifdef VC_MC_QUEUE_HWM_EN
    output logic [p_num_chans*(c_addr_nbits+1)-1:0] hwm,
`endif
    output logic [p_num_chans*(c_addr_nbits+1)-1:0] num_free_entries
);

    localparam int c_cnt_nbits = c_addr_nbits + 1;
    localparam int c_slots     = 1 << c_chan_nbits;
    localparam int c_mem_depth = p_num_chans * p_num_msgs;
    localparam int c_mem_nbits = $clog2(c_mem_depth);
    localparam bit c_pipe      = (p_type & VC_QUEUE_PIPE) != 0;
    localparam bit c_bypass    = (p_type & VC_QUEUE_BYPASS) != 0;

    logic [p_msg_nbits-1:0]  r_mem [c_mem_depth];
    logic [c_addr_nbits-1:0] w_enq_ptr [c_slots];
    logic [c_addr_nbits-1:0] w_deq_ptr [c_slots];
    logic                    w_full    [c_slots];
    logic                    w_empty   [c_slots];
    logic w_enq_chan_ok, w_deq_chan_ok, w_enq_flush_hit, w_deq_flush_hit, w_same_chan;
    logic w_bypass_val, w_do_enq, w_do_deq, w_do_bypass;
    logic [c_mem_nbits-1:0]  w_enq_addr, w_deq_addr;

    // Index space is padded to a power of two; unused slots look full and empty.
    genvar gi;
    generate
        for (gi = 0; gi < c_slots; gi++) begin : g_chan
            if (gi < p_num_chans) begin : g_live
                vc_mc_queue_chan_ctrl #(.p_num_msgs(p_num_msgs)) u_ctrl (
                    .clk       (clk),
                    .reset     (reset),
                    .do_enq    (w_do_enq    && (enq_chan   == c_chan_nbits'(gi))),
                    .do_deq    (w_do_deq    && (deq_chan   == c_chan_nbits'(gi))),
                    .do_bypass (w_do_bypass && (deq_chan   == c_chan_nbits'(gi))),
                    .flush     (flush       && (flush_chan == c_chan_nbits'(gi))),
                    .enq_ptr   (w_enq_ptr[gi]),
                    .deq_ptr   (w_deq_ptr[gi]),
                    .full      (w_full[gi]),
                    .empty     (w_empty[gi]),
`ifdef VC_MC_QUEUE_HWM_EN
                    .hwm       (hwm[gi*c_cnt_nbits +: c_cnt_nbits]),
`endif
                    .num_free  (num_free_entries[gi*c_cnt_nbits +: c_cnt_nbits])
                );
            end else begin : g_pad
                assign w_enq_ptr[gi] = '0;
                assign w_deq_ptr[gi] = '0;
                assign w_full[gi]    = 1'b1;
                assign w_empty[gi]   = 1'b1;
            end
        end
    endgenerate

    assign w_enq_chan_ok   = int'(enq_chan) < p_num_chans;
    assign w_deq_chan_ok   = int'(deq_chan) < p_num_chans;
    assign w_enq_flush_hit = flush && (flush_chan == enq_chan);
    assign w_deq_flush_hit = flush && (flush_chan == deq_chan);
    assign w_same_chan     = enq_chan == deq_chan;

    // rdy depends on deq_rdy and val on enq_val, never on each other: no comb loop.
    assign enq_rdy = w_enq_chan_ok && !w_enq_flush_hit &&
                     (!w_full[enq_chan] || (c_pipe && deq_rdy && w_same_chan));
    assign w_bypass_val = c_bypass && w_empty[deq_chan] && enq_val && w_same_chan;
    assign deq_val = w_deq_chan_ok && !w_deq_flush_hit &&
                     (!w_empty[deq_chan] || w_bypass_val);

    assign w_do_enq    = enq_val && enq_rdy;
    assign w_do_deq    = deq_val && deq_rdy;
    assign w_do_bypass = w_do_deq && w_empty[deq_chan];

    assign w_enq_addr = c_mem_nbits'(int'(enq_chan) * p_num_msgs + int'(w_enq_ptr[enq_chan]));
    assign w_deq_addr = c_mem_nbits'(int'(deq_chan) * p_num_msgs + int'(w_deq_ptr[deq_chan]));

    always_ff @(posedge clk) begin
        if (w_do_enq && !w_do_bypass) r_mem[w_enq_addr] <= enq_msg;
    end

    assign deq_msg = (c_bypass && w_empty[deq_chan]) ? enq_msg : r_mem[w_deq_addr];

    a_strobes_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({enq_val, deq_rdy, flush}));
    a_enq_chan_range: assert property (@(posedge clk) disable iff (reset)
        enq_val |-> (int'(enq_chan) < p_num_chans));
    a_deq_chan_range: assert property (@(posedge clk) disable iff (reset)
        deq_rdy |-> (int'(deq_chan) < p_num_chans));
    a_flush_chan_range: assert property (@(posedge clk) disable iff (reset)
        flush |-> (int'(flush_chan) < p_num_chans));

endmodule

// File: tb/tb_vc_mc_queue.sv
// Directed bench for vc_mc_queue built with PIPE|BYPASS, 4 entries x 2 channels.
module tb_vc_mc_queue;
    import vc_queue_pkg::*;

    logic        clk = 1'b0, reset = 1'b1;
    logic        enq_val = 1'b0, deq_rdy = 1'b0, flush = 1'b0;
    logic [0:0]  enq_chan = '0, deq_chan = '0, flush_chan = '0;
    logic [31:0] enq_msg = '0;
    logic        enq_rdy, deq_val;
    logic [31:0] deq_msg;
    logic [5:0]  num_free_entries;
    int          checks = 0, errors = 0;

    vc_mc_queue #(
        .p_type      (VC_QUEUE_PIPE | VC_QUEUE_BYPASS),
        .p_msg_nbits (32),
        .p_num_msgs  (4),
        .p_num_chans (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (enq_val),
        .enq_rdy          (enq_rdy),
        .enq_chan         (enq_chan),
        .enq_msg          (enq_msg),
        .deq_val          (deq_val),
        .deq_rdy          (deq_rdy),
        .deq_chan         (deq_chan),
        .deq_msg          (deq_msg),
        .flush            (flush),
        .flush_chan       (flush_chan),
        .num_free_entries (num_free_entries)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        flush   = 1'b0;
    endtask

    // deq_chan points at the other channel so the push never bypasses.
    task automatic push(input logic ch, input logic [31:0] m);
        enq_val = 1'b1; enq_chan = ch; enq_msg = m;
        deq_rdy = 1'b0; deq_chan = ~ch;
        #1;
        $display("enq ch%0d msg %h rdy %0b", ch, m, enq_rdy);
        tick();
        idle();
    endtask

    task automatic pop(input logic ch, output logic v, output logic [31:0] m);
        enq_val = 1'b0; deq_chan = ch; deq_rdy = 1'b1;
        #1;
        v = deq_val;
        m = deq_msg;
        $display("deq ch%0d val %0b msg %h", ch, v, m);
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; enq_val = 1'b1; enq_chan = 1'b0; enq_msg = 32'hFF;
        tick(); tick();
        reset = 1'b0; idle(); deq_chan = 1'b0; enq_chan = 1'b0;
        #1;
        checks++; if (enq_rdy !== 1'b1) begin errors++; $display("FAIL reset_enq_rdy got %b exp 1", enq_rdy); end
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL reset_deq_val got %b exp 0", deq_val); end
        checks++; if (num_free_entries !== 6'b100_100) begin errors++; $display("FAIL reset_counts got %b exp 100100", num_free_entries); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push(1'b0, 32'hA0 + 32'(i));
        enq_val = 1'b1; enq_chan = 1'b0; deq_chan = 1'b1; deq_rdy = 1'b0;
        #1;
        checks++; if (enq_rdy !== 1'b0) begin errors++; $display("FAIL fill_ch0_rdy got %b exp 0", enq_rdy); end
        checks++; if (num_free_entries[2:0] !== 3'd0) begin errors++; $display("FAIL fill_count0 got %0d exp 0", num_free_entries[2:0]); end
        enq_chan = 1'b1;
        #1;
        checks++; if (enq_rdy !== 1'b1) begin errors++; $display("FAIL fill_ch1_rdy got %b exp 1", enq_rdy); end
        checks++; if (num_free_entries[5:3] !== 3'd4) begin errors++; $display("FAIL fill_count1 got %0d exp 4", num_free_entries[5:3]); end
        deq_chan = 1'b0;
        #1;
        checks++; if (deq_val !== 1'b1 || deq_msg !== 32'hA0) begin errors++; $display("FAIL fill_head got val=%b msg=%h exp val=1 msg=000000a0", deq_val, deq_msg); end
        idle();
    endtask

    task automatic test_interleave();
        logic v; logic [31:0] m;
        push(1'b1, 32'h11);
        pop(1'b0, v, m);
        checks++; if (v !== 1'b1 || m !== 32'hA0) begin errors++; $display("FAIL interleave_ch0 got val=%b msg=%h exp val=1 msg=000000a0", v, m); end
        pop(1'b1, v, m);
        checks++; if (v !== 1'b1 || m !== 32'h11) begin errors++; $display("FAIL interleave_ch1 got val=%b msg=%h exp val=1 msg=00000011", v, m); end
        #1;
        checks++; if (num_free_entries !== 6'b100_001) begin errors++; $display("FAIL interleave_counts got %b exp 100001", num_free_entries); end
    endtask

    task automatic test_wrap();
        logic v; logic [31:0] m;
        for (int k = 0; k < 10; k++) begin
            push(1'b1, 32'(k));
            pop(1'b1, v, m);
            checks++; if (v !== 1'b1 || m !== 32'(k)) begin errors++; $display("FAIL wrap_%0d got val=%b msg=%h exp val=1 msg=%h", k, v, m, 32'(k)); end
        end
        #1;
        checks++; if (num_free_entries[5:3] !== 3'd4) begin errors++; $display("FAIL wrap_count1 got %0d exp 4", num_free_entries[5:3]); end
    endtask

    task automatic test_pipe();
        logic v; logic [31:0] m;
        logic [31:0] exp_q [4] = '{32'hA2, 32'hA3, 32'hA4, 32'hB0};
        push(1'b0, 32'hA4);
        #1;
        checks++; if (num_free_entries[2:0] !== 3'd0) begin errors++; $display("FAIL pipe_full got %0d exp 0", num_free_entries[2:0]); end
        enq_val = 1'b1; enq_chan = 1'b0; enq_msg = 32'hB0; deq_chan = 1'b0; deq_rdy = 1'b1;
        #1;
        $display("enq+deq ch0 msg b0 rdy %0b val %0b head %h", enq_rdy, deq_val, deq_msg);
        checks++; if (enq_rdy !== 1'b1 || deq_val !== 1'b1 || deq_msg !== 32'hA1) begin errors++; $display("FAIL pipe_same_cycle got rdy=%b val=%b msg=%h exp rdy=1 val=1 msg=000000a1", enq_rdy, deq_val, deq_msg); end
        tick(); idle();
        #1;
        checks++; if (num_free_entries[2:0] !== 3'd0) begin errors++; $display("FAIL pipe_count0 got %0d exp 0", num_free_entries[2:0]); end
        for (int i = 0; i < 4; i++) begin
            pop(1'b0, v, m);
            checks++; if (v !== 1'b1 || m !== exp_q[i]) begin errors++; $display("FAIL pipe_drain_%0d got val=%b msg=%h exp val=1 msg=%h", i, v, m, exp_q[i]); end
        end
        #1;
        checks++; if (num_free_entries[2:0] !== 3'd4) begin errors++; $display("FAIL pipe_empty_count got %0d exp 4", num_free_entries[2:0]); end
    endtask

    task automatic test_bypass();
        enq_val = 1'b1; enq_chan = 1'b1; enq_msg = 32'h55; deq_chan = 1'b1; deq_rdy = 1'b1;
        #1;
        $display("bypass ch1 msg 55 val %0b out %h", deq_val, deq_msg);
        checks++; if (enq_rdy !== 1'b1 || deq_val !== 1'b1 || deq_msg !== 32'h55) begin errors++; $display("FAIL bypass got rdy=%b val=%b msg=%h exp rdy=1 val=1 msg=00000055", enq_rdy, deq_val, deq_msg); end
        tick(); idle();
        #1;
        checks++; if (num_free_entries[5:3] !== 3'd4 || deq_val !== 1'b0) begin errors++; $display("FAIL bypass_after got count1=%0d val=%b exp count1=4 val=0", num_free_entries[5:3], deq_val); end
    endtask

    task automatic test_flush();
        logic v; logic [31:0] m;
        for (int i = 0; i < 3; i++) push(1'b0, 32'hC0 + 32'(i));
        push(1'b1, 32'hD0);
        flush = 1'b1; flush_chan = 1'b0;
        enq_val = 1'b1; enq_chan = 1'b0; enq_msg = 32'hEE; deq_chan = 1'b0; deq_rdy = 1'b0;
        #1;
        $display("flush ch0 enq_rdy %0b deq_val %0b", enq_rdy, deq_val);
        checks++; if (enq_rdy !== 1'b0 || deq_val !== 1'b0) begin errors++; $display("FAIL flush_block got rdy=%b val=%b exp rdy=0 val=0", enq_rdy, deq_val); end
        deq_chan = 1'b1;
        #1;
        checks++; if (deq_val !== 1'b1) begin errors++; $display("FAIL flush_isolation got val=%b exp 1", deq_val); end
        tick(); idle(); deq_chan = 1'b0;
        #1;
        checks++; if (num_free_entries !== 6'b011_100 || deq_val !== 1'b0) begin errors++; $display("FAIL flush_after got counts=%b val=%b exp counts=011100 val=0", num_free_entries, deq_val); end
        pop(1'b1, v, m);
        checks++; if (v !== 1'b1 || m !== 32'hD0) begin errors++; $display("FAIL flush_ch1_data got val=%b msg=%h exp val=1 msg=000000d0", v, m); end
    endtask

    task automatic test_back_to_back();
        logic v; logic [31:0] m;
        push(1'b0, 32'hE0);
        pop(1'b0, v, m);
        checks++; if (v !== 1'b1 || m !== 32'hE0) begin errors++; $display("FAIL b2b_latency got val=%b msg=%h exp val=1 msg=000000e0", v, m); end
        push(1'b0, 32'hE1);
        enq_val = 1'b1; enq_chan = 1'b1; enq_msg = 32'hF1; deq_chan = 1'b0; deq_rdy = 1'b1;
        #1;
        $display("enq ch1 msg f1 + deq ch0 msg %h", deq_msg);
        checks++; if (enq_rdy !== 1'b1 || deq_val !== 1'b1 || deq_msg !== 32'hE1) begin errors++; $display("FAIL b2b_cross got rdy=%b val=%b msg=%h exp rdy=1 val=1 msg=000000e1", enq_rdy, deq_val, deq_msg); end
        tick(); idle();
        #1;
        checks++; if (num_free_entries !== 6'b011_100) begin errors++; $display("FAIL b2b_counts got %b exp 011100", num_free_entries); end
        pop(1'b1, v, m);
        checks++; if (v !== 1'b1 || m !== 32'hF1) begin errors++; $display("FAIL b2b_ch1 got val=%b msg=%h exp val=1 msg=000000f1", v, m); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_interleave();
        test_wrap();
        test_pipe();
        test_bypass();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
